// File: rtl/eh2_lsu_ecc_scrub.sv
// DCCM ECC scrubber: collects corrected single-bit errors into a coalescing
// writeback queue, re-encodes the head entry, and keeps SBE/DBE statistics.
module eh2_lsu_ecc_scrub #(
   parameter int NBANK  = 2,
   parameter int DW     = 32,
   parameter int EW     = 7,
   parameter int AW     = 16,
   parameter int QDEPTH = 4,
   parameter int CW     = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NBANK-1:0]    det_valid,
   input  logic [NBANK-1:0]    det_sbe,
   input  logic [NBANK-1:0]    det_dbe,
   input  logic [NBANK*AW-1:0] det_addr,
   input  logic [NBANK*DW-1:0] det_cdata,
   input  logic                ecc_disable,
   output logic                wb_valid,
   input  logic                wb_ready,
   output logic [AW-1:0]       wb_addr,
   output logic [DW-1:0]       wb_data,
   output logic [EW-1:0]       wb_ecc,
   output logic [CW-1:0]       sbe_cnt,
   output logic [CW-1:0]       dbe_cnt,
   input  logic                cnt_clr,
   input  logic [CW-1:0]       sbe_thresh,
   output logic                sbe_irq,
   output logic                q_ovf
);

   localparam int QAW = $clog2(QDEPTH);
   localparam int PW  = QAW + 1;
   localparam int SW  = CW + 3;

   // Hamming SECDED: data bits occupy the non-power-of-two code positions
   // starting at 3; the top bit is overall parity over data and check bits.
   function automatic logic [EW-1:0] secded_encode(input logic [DW-1:0] d);
      logic [EW-1:0] e;
      int            j;
      e = '0;
      j = 0;
      for (int p = 3; p < (1 << (EW-1)); p++) begin
         if (((p & (p - 1)) != 0) && (j < DW)) begin
            for (int k = 0; k < EW-1; k++) begin
               if (p[k]) e[k] = e[k] ^ d[j];
            end
            j++;
         end
      end
      e[EW-1] = ^{d, e[EW-2:0]};
      return e;
   endfunction

   logic [PW-1:0]     wptr, rptr, wptr_n, rptr_n;
   logic [QDEPTH-1:0] q_vld, vld_n;
   logic [AW-1:0]     q_addr [QDEPTH];
   logic [DW-1:0]     q_data [QDEPTH];
   logic [AW-1:0]     addr_n [QDEPTH];
   logic [DW-1:0]     data_n [QDEPTH];

   logic [QAW-1:0]    head;
   logic              pop;
   logic              drop;
   logic              hit;
   logic [QAW-1:0]    hit_idx;
   logic [QAW-1:0]    slot;

   logic [NBANK-1:0]  qual, sbe_q, dbe_q;
   logic [2:0]        sbe_pc, dbe_pc;
   logic [SW-1:0]     sbe_sum, dbe_sum;
   logic [CW-1:0]     sbe_cnt_n, dbe_cnt_n;
   logic              irq_n, ovf_n;

   // Writeback handshake: wb_valid is high whenever the queue holds an entry;
   // an entry transfers on a cycle with wb_valid & wb_ready, otherwise the
   // head (wb_addr/wb_data/wb_ecc) holds steady.
   assign head     = rptr[QAW-1:0];
   assign wb_valid = (wptr != rptr);
   assign pop      = wb_valid & wb_ready;
   assign wb_addr  = wb_valid ? q_addr[head] : '0;
   assign wb_data  = wb_valid ? q_data[head] : '0;
   assign wb_ecc   = secded_encode(wb_data);

   assign qual  = det_valid & {NBANK{~ecc_disable}};
   assign dbe_q = qual & det_dbe;
   assign sbe_q = qual & det_sbe & ~det_dbe;

   // Queue update: retire the head first, then place each bank's SBE in
   // bank order, merging into any live entry with the same address.
   always_comb begin
      vld_n   = q_vld;
      wptr_n  = wptr;
      rptr_n  = rptr + PW'(pop);
      drop    = 1'b0;
      hit     = 1'b0;
      hit_idx = '0;
      slot    = '0;
      for (int j = 0; j < QDEPTH; j++) begin
         addr_n[j] = q_addr[j];
         data_n[j] = q_data[j];
      end
      if (pop) vld_n[head] = 1'b0;
      for (int b = 0; b < NBANK; b++) begin
         hit     = 1'b0;
         hit_idx = '0;
         if (sbe_q[b]) begin
            for (int j = 0; j < QDEPTH; j++) begin
               if (!hit && vld_n[j] && (addr_n[j] == det_addr[b*AW +: AW])) begin
                  hit     = 1'b1;
                  hit_idx = QAW'(j);
               end
            end
            if (hit) begin
               data_n[hit_idx] = det_cdata[b*DW +: DW];
            end else if ((wptr_n - rptr_n) != PW'(QDEPTH)) begin
               slot         = wptr_n[QAW-1:0];
               vld_n[slot]  = 1'b1;
               addr_n[slot] = det_addr[b*AW +: AW];
               data_n[slot] = det_cdata[b*DW +: DW];
               wptr_n       = wptr_n + PW'(1);
            end else begin
               drop = 1'b1;
            end
         end
      end
   end

   // Statistics: a clear zeroes the old value before this cycle's events add in.
   always_comb begin
      sbe_pc = '0;
      dbe_pc = '0;
      for (int b = 0; b < NBANK; b++) begin
         sbe_pc = sbe_pc + {2'b00, sbe_q[b]};
         dbe_pc = dbe_pc + {2'b00, dbe_q[b]};
      end
      sbe_sum   = (cnt_clr ? {SW{1'b0}} : {3'b000, sbe_cnt}) + {{CW{1'b0}}, sbe_pc};
      dbe_sum   = (cnt_clr ? {SW{1'b0}} : {3'b000, dbe_cnt}) + {{CW{1'b0}}, dbe_pc};
      sbe_cnt_n = (|sbe_sum[SW-1:CW]) ? {CW{1'b1}} : sbe_sum[CW-1:0];
      dbe_cnt_n = (|dbe_sum[SW-1:CW]) ? {CW{1'b1}} : dbe_sum[CW-1:0];
      irq_n     = (sbe_thresh != '0) && (sbe_cnt < sbe_thresh) && (sbe_cnt_n >= sbe_thresh);
      ovf_n     = (q_ovf & ~cnt_clr) | drop;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr    <= '0;
         rptr    <= '0;
         q_vld   <= '0;
         sbe_cnt <= '0;
         dbe_cnt <= '0;
         sbe_irq <= 1'b0;
         q_ovf   <= 1'b0;
         for (int j = 0; j < QDEPTH; j++) begin
            q_addr[j] <= '0;
            q_data[j] <= '0;
         end
      end else begin
         wptr    <= wptr_n;
         rptr    <= rptr_n;
         q_vld   <= vld_n;
         sbe_cnt <= sbe_cnt_n;
         dbe_cnt <= dbe_cnt_n;
         sbe_irq <= irq_n;
         q_ovf   <= ovf_n;
         for (int j = 0; j < QDEPTH; j++) begin
            q_addr[j] <= addr_n[j];
            q_data[j] <= data_n[j];
         end
      end
   end

endmodule

// File: tb/tb_eh2_lsu_ecc_scrub.sv
// Bench for eh2_lsu_ecc_scrub: directed vector table, multi-cycle corner
// sequences, then randomized traffic against a queue-level reference model.
module tb_eh2_lsu_ecc_scrub;

   localparam int NBANK = 2, DW = 32, EW = 7, AW = 16, QDEPTH = 4, CW = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NBANK-1:0]  det_valid = '0, det_sbe = '0, det_dbe = '0;
   logic [NBANK*AW-1:0] det_addr = '0;
   logic [NBANK*DW-1:0] det_cdata = '0;
   logic              ecc_disable = 1'b0;
   logic              wb_valid, wb_ready = 1'b0;
   logic [AW-1:0]     wb_addr;
   logic [DW-1:0]     wb_data;
   logic [EW-1:0]     wb_ecc;
   logic [CW-1:0]     sbe_cnt, dbe_cnt;
   logic              cnt_clr = 1'b0;
   logic [CW-1:0]     sbe_thresh = '0;
   logic              sbe_irq, q_ovf;

   int checks = 0;
   int failures = 0;

   eh2_lsu_ecc_scrub #(.NBANK(NBANK), .DW(DW), .EW(EW), .AW(AW), .QDEPTH(QDEPTH), .CW(CW)) dut (
      .clk(clk), .rst(rst), .det_valid(det_valid), .det_sbe(det_sbe), .det_dbe(det_dbe),
      .det_addr(det_addr), .det_cdata(det_cdata), .ecc_disable(ecc_disable),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
      .wb_ecc(wb_ecc), .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt), .cnt_clr(cnt_clr),
      .sbe_thresh(sbe_thresh), .sbe_irq(sbe_irq), .q_ovf(q_ovf)
   );

   // clock / reset
   always #5 clk = ~clk;

   // SECDED as XOR of the code positions of the set data bits, plus overall parity.
   function automatic logic [6:0] ref_ecc(input logic [31:0] d);
      logic [5:0] syn;
      int pos;
      syn = '0;
      pos = 2;
      for (int i = 0; i < 32; i++) begin
         pos++;
         while ((pos & (pos - 1)) == 0) pos++;
         if (d[i]) syn = syn ^ pos[5:0];
      end
      return {(^d) ^ (^syn), syn};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, sbe, dbe, input logic [15:0] a0, a1,
                        input logic [31:0] d0, d1, input logic rdy, clr, dis,
                        input logic [3:0] thr);
      det_valid   = v;
      det_sbe     = sbe;
      det_dbe     = dbe;
      det_addr    = {a1, a0};
      det_cdata   = {d1, d0};
      wb_ready    = rdy;
      cnt_clr     = clr;
      ecc_disable = dis;
      sbe_thresh  = thr;
   endtask

   task automatic check_outs(input string tag, input logic e_vld, input logic [15:0] e_addr,
                             input logic [31:0] e_data, input logic [3:0] e_sbe, e_dbe,
                             input logic e_ovf, e_irq);
      chk({tag, ".wb_valid"}, 64'(wb_valid), 64'(e_vld));
      chk({tag, ".wb_addr"},  64'(wb_addr),  64'(e_addr));
      chk({tag, ".wb_data"},  64'(wb_data),  64'(e_data));
      chk({tag, ".wb_ecc"},   64'(wb_ecc),   64'(ref_ecc(e_data)));
      chk({tag, ".sbe_cnt"},  64'(sbe_cnt),  64'(e_sbe));
      chk({tag, ".dbe_cnt"},  64'(dbe_cnt),  64'(e_dbe));
      chk({tag, ".q_ovf"},    64'(q_ovf),    64'(e_ovf));
      chk({tag, ".sbe_irq"},  64'(sbe_irq),  64'(e_irq));
   endtask

   typedef struct {
      logic [1:0]  v, sbe, dbe;
      logic [15:0] a0, a1;
      logic [31:0] d0, d1;
      logic        rdy, clr, dis;
      logic [3:0]  thr;
      logic        e_vld;
      logic [15:0] e_addr;
      logic [31:0] e_data;
      logic [3:0]  e_sbe, e_dbe;
      logic        e_ovf, e_irq;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [1:0] v, sbe, dbe, input logic [15:0] a0, a1,
                      input logic [31:0] d0, d1, input logic rdy, clr, dis, input logic [3:0] thr,
                      input logic e_vld, input logic [15:0] e_addr, input logic [31:0] e_data,
                      input logic [3:0] e_sbe, e_dbe, input logic e_ovf, e_irq);
      vec_t t;
      t = '{v, sbe, dbe, a0, a1, d0, d1, rdy, clr, dis, thr, e_vld, e_addr, e_data, e_sbe, e_dbe, e_ovf, e_irq};
      tbl.push_back(t);
   endtask

   // scoreboard: expected queue of {addr, data}, plus counters
   logic [AW+DW-1:0] exp_q[$];
   int m_sbe, m_dbe;
   logic m_ovf, m_irq;

   task automatic model_step();
      int old_sbe, ns, nd, idx;
      logic drop;
      old_sbe = m_sbe;
      ns = 0; nd = 0; drop = 1'b0;
      if (exp_q.size() > 0 && wb_ready) void'(exp_q.pop_front());
      for (int b = 0; b < NBANK; b++) begin
         if (det_valid[b] && !ecc_disable) begin
            if (det_dbe[b]) nd++;
            else if (det_sbe[b]) begin
               ns++;
               idx = -1;
               for (int k = 0; k < exp_q.size(); k++)
                  if (idx < 0 && exp_q[k][AW+DW-1:DW] == det_addr[b*AW +: AW]) idx = k;
               if (idx >= 0) exp_q[idx][DW-1:0] = det_cdata[b*DW +: DW];
               else if (exp_q.size() < QDEPTH) exp_q.push_back({det_addr[b*AW +: AW], det_cdata[b*DW +: DW]});
               else drop = 1'b1;
            end
         end
      end
      m_sbe = (cnt_clr ? 0 : m_sbe) + ns;
      if (m_sbe > 15) m_sbe = 15;
      m_dbe = (cnt_clr ? 0 : m_dbe) + nd;
      if (m_dbe > 15) m_dbe = 15;
      m_ovf = (m_ovf && !cnt_clr) || drop;
      m_irq = (sbe_thresh != 0) && (old_sbe < int'(sbe_thresh)) && (m_sbe >= int'(sbe_thresh));
   endtask

   initial begin
      logic [15:0] e_a;
      logic [31:0] e_d;
      // reset state
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      #1 check_outs("reset", 1'b0, 16'h0, 32'h0, 4'd0, 4'd0, 1'b0, 1'b0);

      //   v     sbe    dbe    a0      a1      d0            d1            rdy clr dis thr | vld addr data sbe dbe ovf irq
      add(2'b01, 2'b01, 2'b00, 16'h40, 16'h0,  32'hDEADBEEF, 32'h0,        1, 0, 0, 0, 1, 16'h40, 32'hDEADBEEF, 1, 0, 0, 0);
      add(2'b00, 2'b00, 2'b00, 16'h0,  16'h0,  32'h0,        32'h0,        1, 0, 0, 0, 0, 16'h0,  32'h0,        1, 0, 0, 0);
      add(2'b11, 2'b11, 2'b00, 16'h10, 16'h10, 32'h11111111, 32'h22222222, 0, 0, 0, 0, 1, 16'h10, 32'h22222222, 3, 0, 0, 0);
      add(2'b00, 2'b00, 2'b00, 16'h0,  16'h0,  32'h0,        32'h0,        0, 0, 0, 0, 1, 16'h10, 32'h22222222, 3, 0, 0, 0);
      add(2'b00, 2'b00, 2'b00, 16'h0,  16'h0,  32'h0,        32'h0,        1, 0, 0, 0, 0, 16'h0,  32'h0,        3, 0, 0, 0);
      add(2'b11, 2'b11, 2'b00, 16'h100,16'h104,32'h1,        32'h2,        0, 0, 0, 0, 1, 16'h100,32'h1,        5, 0, 0, 0);
      add(2'b11, 2'b11, 2'b00, 16'h108,16'h10C,32'h3,        32'h4,        0, 0, 0, 0, 1, 16'h100,32'h1,        7, 0, 0, 0);
      add(2'b01, 2'b01, 2'b00, 16'h110,16'h0,  32'h5,        32'h0,        0, 0, 0, 0, 1, 16'h100,32'h1,        8, 0, 1, 0);
      add(2'b11, 2'b11, 2'b00, 16'h104,16'h200,32'h22,       32'h6,        0, 0, 0, 0, 1, 16'h100,32'h1,       10, 0, 1, 0);
      add(2'b01, 2'b01, 2'b00, 16'h300,16'h0,  32'h33,       32'h0,        1, 0, 0, 0, 1, 16'h104,32'h22,      11, 0, 1, 0);
      add(2'b01, 2'b01, 2'b00, 16'h108,16'h0,  32'h44,       32'h0,        1, 0, 0, 0, 1, 16'h108,32'h44,      12, 0, 1, 0);
      add(2'b00, 2'b00, 2'b00, 16'h0,  16'h0,  32'h0,        32'h0,        1, 0, 0, 0, 1, 16'h10C,32'h4,       12, 0, 1, 0);
      add(2'b01, 2'b01, 2'b00, 16'h10C,16'h0,  32'h55,       32'h0,        1, 0, 0, 0, 1, 16'h300,32'h33,      13, 0, 1, 0);
      add(2'b00, 2'b00, 2'b00, 16'h0,  16'h0,  32'h0,        32'h0,        1, 0, 0, 0, 1, 16'h10C,32'h55,      13, 0, 1, 0);
      add(2'b00, 2'b00, 2'b00, 16'h0,  16'h0,  32'h0,        32'h0,        1, 0, 0, 0, 0, 16'h0,  32'h0,       13, 0, 1, 0);
      add(2'b11, 2'b11, 2'b01, 16'h0,  16'h20, 32'h77,       32'h66,       0, 0, 0, 0, 1, 16'h20, 32'h66,      14, 1, 1, 0);
      add(2'b11, 2'b00, 2'b11, 16'h0,  16'h0,  32'h0,        32'h0,        1, 0, 0, 0, 0, 16'h0,  32'h0,       14, 3, 1, 0);
      add(2'b11, 2'b11, 2'b00, 16'h70, 16'h74, 32'h1,        32'h2,        1, 0, 1, 0, 0, 16'h0,  32'h0,       14, 3, 1, 0);
      add(2'b00, 2'b11, 2'b11, 16'h70, 16'h74, 32'h1,        32'h2,        1, 0, 0, 0, 0, 16'h0,  32'h0,       14, 3, 1, 0);
      add(2'b11, 2'b11, 2'b00, 16'h30, 16'h34, 32'hA,        32'hB,        0, 0, 0, 0, 1, 16'h30, 32'hA,       15, 3, 1, 0);
      add(2'b01, 2'b00, 2'b01, 16'h0,  16'h0,  32'h0,        32'h0,        1, 1, 0, 0, 1, 16'h34, 32'hB,        0, 1, 0, 0);
      add(2'b00, 2'b00, 2'b00, 16'h0,  16'h0,  32'h0,        32'h0,        1, 0, 0, 0, 0, 16'h0,  32'h0,        0, 1, 0, 0);
      add(2'b01, 2'b01, 2'b00, 16'h50, 16'h0,  32'hC1,       32'h0,        1, 0, 0, 3, 1, 16'h50, 32'hC1,       1, 1, 0, 0);
      add(2'b01, 2'b01, 2'b00, 16'h54, 16'h0,  32'hC2,       32'h0,        1, 0, 0, 3, 1, 16'h54, 32'hC2,       2, 1, 0, 0);
      add(2'b01, 2'b01, 2'b00, 16'h58, 16'h0,  32'hC3,       32'h0,        1, 0, 0, 3, 1, 16'h58, 32'hC3,       3, 1, 0, 1);
      add(2'b00, 2'b00, 2'b00, 16'h0,  16'h0,  32'h0,        32'h0,        1, 0, 0, 3, 0, 16'h0,  32'h0,        3, 1, 0, 0);
      add(2'b01, 2'b01, 2'b00, 16'h5C, 16'h0,  32'hC4,       32'h0,        0, 0, 0, 3, 1, 16'h5C, 32'hC4,       4, 1, 0, 0);
      add(2'b00, 2'b00, 2'b00, 16'h0,  16'h0,  32'h0,        32'h0,        1, 0, 0, 3, 0, 16'h0,  32'h0,        4, 1, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].v, tbl[i].sbe, tbl[i].dbe, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1,
               tbl[i].rdy, tbl[i].clr, tbl[i].dis, tbl[i].thr);
         tick();
         check_outs($sformatf("vec%0d", i), tbl[i].e_vld, tbl[i].e_addr, tbl[i].e_data,
                    tbl[i].e_sbe, tbl[i].e_dbe, tbl[i].e_ovf, tbl[i].e_irq);
      end

      // DBE saturation at 15, then clear coinciding with one DBE
      drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0, 1, 1, 0, 0);
      tick();
      chk("sat.clr", 64'(dbe_cnt), 64'd0);
      for (int k = 1; k <= 10; k++) begin
         drive(2'b11, 2'b00, 2'b11, 16'h0, 16'h0, 32'h0, 32'h0, 1, 0, 0, 0);
         tick();
         chk($sformatf("sat.dbe%0d", k), 64'(dbe_cnt), 64'((2 * k > 15) ? 15 : 2 * k));
      end
      drive(2'b01, 2'b00, 2'b01, 16'h0, 16'h0, 32'h0, 32'h0, 1, 1, 0, 0);
      tick();
      chk("sat.clr_with_dbe", 64'(dbe_cnt), 64'd1);

      // reset while stalled holding three entries
      drive(2'b11, 2'b11, 2'b00, 16'h1, 16'h2, 32'h1, 32'h2, 0, 0, 0, 0);
      tick();
      drive(2'b01, 2'b01, 2'b00, 16'h3, 16'h0, 32'h3, 32'h0, 0, 0, 0, 0);
      tick();
      drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0, 0, 0, 0, 0);
      chk("rst.held", 64'(wb_valid), 64'd1);
      #1 rst = 1'b1;
      #1 check_outs("rst.async", 1'b0, 16'h0, 32'h0, 4'd0, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      wb_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_outs($sformatf("rst.after%0d", k), 1'b0, 16'h0, 32'h0, 4'd0, 4'd0, 1'b0, 1'b0);
      end

      // randomized traffic against the reference model
      exp_q.delete();
      m_sbe = 0; m_dbe = 0; m_ovf = 1'b0; m_irq = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         drive(2'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
               16'($urandom_range(0, 7) * 4), 16'($urandom_range(0, 7) * 4), $urandom, $urandom,
               ($urandom_range(0, 3) != 0) ^ (c % 200 < 60), $urandom_range(0, 15) == 0,
               $urandom_range(0, 9) == 0, (c % 100 == 0) ? 4'($urandom) : sbe_thresh);
         model_step();
         tick();
         e_a = (exp_q.size() > 0) ? exp_q[0][AW+DW-1:DW] : 16'h0;
         e_d = (exp_q.size() > 0) ? exp_q[0][DW-1:0] : 32'h0;
         check_outs($sformatf("rnd%0d", c), exp_q.size() > 0, e_a, e_d,
                    4'(m_sbe), 4'(m_dbe), m_ovf, m_irq);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
